// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD-RLS input sequencing stage.
//   QRD_N           default lane count (array columns)
//   QRD_DATA_LENGTH default bits per lane sample
//   QRD_SKEW        default per-cell latency of the systolic array
//   qrd_state_t     frame FSM state encoding
package qrd_pkg;

   localparam int QRD_N           = 4;
   localparam int QRD_DATA_LENGTH = 8;
   localparam int QRD_SKEW        = 22;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } qrd_state_t;

endpackage

// File: rtl/qrd_lane_delay_rst.sv
// Resettable fixed-depth shift line. A word presented on din appears on dout
// DEPTH clock edges later. Synchronous reset clears every stage so no stale
// word can leave the line after reset.
//   clk   clock
//   rst   synchronous active-high reset
//   din   word entering the line (WIDTH bits)
//   dout  word leaving the line (WIDTH bits, registered)
module qrd_lane_delay_rst #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/qrd_input_skew.sv
// Input sequencing stage in front of the QRD-RLS systolic array. Accepts one
// N-lane vector per valid/ready handshake and releases lane k SKEW*k cycles
// after lane 0. Vectors are grouped into frames of FRAME_LEN; after the last
// vector of a frame, input is blocked until that vector has fully entered the
// array, then frame_done pulses for one cycle.
//   clk         clock
//   rst         synchronous active-high reset
//   in_data     N lanes, lane k at [k*DATA_LENGTH +: DATA_LENGTH]
//   in_valid    vector offered
//   in_ready    stage can accept (registered)
//   out_data    skewed lanes, same packing as in_data (zero when not valid)
//   out_valid   per-lane valid
//   out_sof     per-lane start-of-frame marker
//   frame_done  one-cycle pulse when the frame's last lane has been emitted
//
// state | meaning
// IDLE  | waiting for the first vector of a frame; next accept carries sof
// RUN   | inside a frame, counting accepted vectors
// FLUSH | frame complete, input blocked while the last vector skews out
module qrd_input_skew
   import qrd_pkg::*;
#(
   parameter int N           = QRD_N,
   parameter int DATA_LENGTH = QRD_DATA_LENGTH,
   parameter int SKEW        = QRD_SKEW,
   parameter int FRAME_LEN   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N*DATA_LENGTH-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [N*DATA_LENGTH-1:0] out_data,
   output logic [N-1:0]             out_valid,
   output logic [N-1:0]             out_sof,
   output logic                     frame_done
);

   localparam int LW        = DATA_LENGTH + 2;
   localparam int FLUSH_CYC = (N - 1) * SKEW;
   localparam int VEC_W     = $clog2(FRAME_LEN + 1);
   localparam int FL_W      = $clog2(FLUSH_CYC + 1);

   localparam logic [VEC_W-1:0] FRAME_LEN_C = VEC_W'(FRAME_LEN);
   localparam logic [VEC_W-1:0] VEC_ONE     = VEC_W'(1);
   localparam logic [FL_W-1:0]  FLUSH_LOAD  = FL_W'(FLUSH_CYC);
   localparam logic [FL_W-1:0]  FLUSH_ONE   = FL_W'(1);
   localparam bit               SINGLE      = (FRAME_LEN == 1);

   qrd_state_t         state;
   logic [VEC_W-1:0]   vec_cnt;
   logic [VEC_W-1:0]   vec_cnt_inc;
   logic [FL_W-1:0]    flush_cnt;
   logic               accept;
   logic               first_vec;

   logic [N-1:0][LW-1:0] lane_in;
   logic [N-1:0][LW-1:0] lane_out;

   // in_ready is already low during reset and FLUSH, but rst is kept in the
   // term so nothing is injected into the lane paths while reset is applied.
   assign accept      = in_valid && in_ready && !rst;
   assign first_vec   = (state == IDLE);
   assign vec_cnt_inc = vec_cnt + VEC_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec_cnt    <= '0;
         flush_cnt  <= '0;
         in_ready   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               vec_cnt  <= '0;
               if (accept) begin
                  if (SINGLE) begin
                     state     <= FLUSH;
                     flush_cnt <= FLUSH_LOAD;
                     in_ready  <= 1'b0;
                  end else begin
                     state   <= RUN;
                     vec_cnt <= VEC_ONE;
                  end
               end
            end
            RUN: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (vec_cnt_inc == FRAME_LEN_C) begin
                     state     <= FLUSH;
                     flush_cnt <= FLUSH_LOAD;
                     vec_cnt   <= '0;
                     in_ready  <= 1'b0;
                  end else begin
                     vec_cnt <= vec_cnt_inc;
                  end
               end
            end
            FLUSH: begin
               // Counter reads FLUSH_LOAD in the first FLUSH cycle, so the
               // exit edge lands exactly when the last lane goes out.
               if (flush_cnt == FLUSH_ONE) begin
                  state      <= IDLE;
                  flush_cnt  <= '0;
                  in_ready   <= 1'b1;
                  frame_done <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - FLUSH_ONE;
                  in_ready  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               vec_cnt   <= '0;
               flush_cnt <= '0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

   // Idle cycles inject an all-zero word so out_data is zero whenever the
   // matching out_valid is low.
   always_comb begin
      lane_in = '0;
      for (int k = 0; k < N; k++) begin
         if (accept) begin
            lane_in[k] = {1'b1, first_vec, in_data[k*DATA_LENGTH +: DATA_LENGTH]};
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      qrd_lane_delay_rst #(
         .DEPTH (1 + k * SKEW),
         .WIDTH (LW)
      ) u_delay (
         .clk  (clk),
         .rst  (rst),
         .din  (lane_in[k]),
         .dout (lane_out[k])
      );
   end

   always_comb begin
      out_data  = '0;
      out_valid = '0;
      out_sof   = '0;
      for (int k = 0; k < N; k++) begin
         out_valid[k]                          = lane_out[k][LW-1];
         out_sof[k]                            = lane_out[k][LW-2];
         out_data[k*DATA_LENGTH +: DATA_LENGTH] = lane_out[k][DATA_LENGTH-1:0];
      end
   end

endmodule

// File: tb/tb_qrd_input_skew.sv
module tb_qrd_input_skew;

   localparam int N         = 4;
   localparam int DL        = 8;
   localparam int SKEW      = 22;
   localparam int FLEN      = 4;
   localparam int FLUSH_CYC = (N - 1) * SKEW;
   localparam int MAXE      = 8192;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   in_data;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   out_data;
   logic [3:0]    out_valid;
   logic [3:0]    out_sof;
   logic          frame_done;

   logic          rst1;
   logic [31:0]   in_data1;
   logic          in_valid1;
   logic          in_ready1;
   logic [31:0]   out_data1;
   logic [3:0]    out_valid1;
   logic [3:0]    out_sof1;
   logic          frame_done1;

   always #5 clk = ~clk;

   qrd_input_skew #(.N(N), .DATA_LENGTH(DL), .SKEW(SKEW), .FRAME_LEN(FLEN)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .frame_done(frame_done)
   );

   qrd_input_skew #(.N(N), .DATA_LENGTH(DL), .SKEW(SKEW), .FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_data(out_data1), .out_valid(out_valid1), .out_sof(out_sof1), .frame_done(frame_done1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: history of accepts indexed by edge number. A lane
   // output after edge e is the vector accepted at edge e - k*SKEW, if that
   // accept happened after the most recent reset.
   bit          acc  [0:MAXE-1];
   bit          sofa [0:MAXE-1];
   logic [31:0] dat  [0:MAXE-1];
   int          e         = -1;
   int          last_rst  = -1;
   int          fcnt      = 0;
   int          block_end = -1;
   bit          m_ready   = 1'b0;
   bit          m_done    = 1'b0;
   bit          last_acc  = 1'b0;

   typedef struct {
      int          scn;
      int          cyc;
      bit          rdy;
      bit          done;
      logic [3:0]  v;
      logic [3:0]  sf;
      logic [31:0] d;
   } row_t;
   row_t rows[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s edge=%0d got=%h expected=%h", nm, e, act, exp);
      end
   endtask

   task automatic add_row(input int scn, input int cyc, input bit rdy, input bit done,
                          input logic [3:0] v, input logic [3:0] sf, input logic [31:0] d);
      row_t r;
      r.scn = scn; r.cyc = cyc; r.rdy = rdy; r.done = done; r.v = v; r.sf = sf; r.d = d;
      rows.push_back(r);
   endtask

   task automatic tick();
      int src;
      logic [3:0]  ev;
      logic [3:0]  es;
      logic [31:0] ed;
      @(posedge clk);
      e++;
      if (rst) begin
         last_rst  = e;
         m_ready   = 1'b0;
         m_done    = 1'b0;
         fcnt      = 0;
         block_end = -1;
         acc[e]    = 1'b0;
         last_acc  = 1'b0;
      end else begin
         last_acc = in_valid && m_ready;
         acc[e]   = last_acc;
         dat[e]   = in_data;
         sofa[e]  = last_acc && (fcnt == 0);
         if (last_acc) begin
            fcnt++;
            if (fcnt == FLEN) begin
               fcnt      = 0;
               block_end = e + FLUSH_CYC;
            end
         end
         m_ready = !(e < block_end);
         m_done  = (e == block_end);
      end
      #1;
      ev = '0; es = '0; ed = '0;
      for (int k = 0; k < N; k++) begin
         src = e - k * SKEW;
         if (src > last_rst && acc[src]) begin
            ev[k] = 1'b1;
            es[k] = sofa[src];
            ed[k*DL +: DL] = dat[src][k*DL +: DL];
         end
      end
      chk("model.in_ready",   32'(in_ready),   32'(m_ready));
      chk("model.frame_done", 32'(frame_done), 32'(m_done));
      chk("model.out_valid",  32'(out_valid),  32'(ev));
      chk("model.out_sof",    32'(out_sof),    32'(es));
      chk("model.out_data",   out_data,        ed);
   endtask

   function automatic logic [31:0] vec(input int j);
      logic [31:0] r;
      for (int k = 0; k < N; k++) r[k*DL +: DL] = 8'(16 * k + j);
      return r;
   endfunction

   task automatic run_scn(input int id, input logic [255:0] mask, input int len, input int rst_edge);
      int vidx;
      vidx = 0;
      for (int j = 0; j < len; j++) begin
         rst      = (j == rst_edge);
         in_valid = mask[j];
         in_data  = vec(vidx);
         tick();
         if (last_acc) vidx++;
         foreach (rows[r]) begin
            if (rows[r].scn == id && rows[r].cyc == j + 1) begin
               chk($sformatf("tbl%0d.c%0d.in_ready", id, j + 1),   32'(in_ready),   32'(rows[r].rdy));
               chk($sformatf("tbl%0d.c%0d.frame_done", id, j + 1), 32'(frame_done), 32'(rows[r].done));
               chk($sformatf("tbl%0d.c%0d.out_valid", id, j + 1),  32'(out_valid),  32'(rows[r].v));
               chk($sformatf("tbl%0d.c%0d.out_sof", id, j + 1),    32'(out_sof),    32'(rows[r].sf));
               chk($sformatf("tbl%0d.c%0d.out_data", id, j + 1),   out_data,        rows[r].d);
            end
         end
      end
      rst = 1'b0; in_valid = 1'b0; in_data = '0;
   endtask

   initial begin
      logic [255:0] mask;

      // scenario 1: back-to-back frame, accepts at 10..13
      add_row(1, 11, 1, 0, 4'b0001, 4'b0001, 32'h00000000);
      add_row(1, 12, 1, 0, 4'b0001, 4'b0000, 32'h00000001);
      add_row(1, 14, 0, 0, 4'b0001, 4'b0000, 32'h00000003);
      add_row(1, 15, 0, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(1, 33, 0, 0, 4'b0010, 4'b0010, 32'h00001000);
      add_row(1, 77, 0, 0, 4'b1000, 4'b1000, 32'h30000000);
      add_row(1, 79, 0, 0, 4'b1000, 4'b0000, 32'h32000000);
      add_row(1, 80, 1, 1, 4'b1000, 4'b0000, 32'h33000000);
      add_row(1, 81, 1, 0, 4'b0000, 4'b0000, 32'h00000000);
      // scenario 2: gapped, accepts at 10,12,15,16
      add_row(2, 11, 1, 0, 4'b0001, 4'b0001, 32'h00000000);
      add_row(2, 12, 1, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(2, 13, 1, 0, 4'b0001, 4'b0000, 32'h00000001);
      add_row(2, 15, 1, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(2, 17, 0, 0, 4'b0001, 4'b0000, 32'h00000003);
      add_row(2, 78, 0, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(2, 79, 0, 0, 4'b1000, 4'b0000, 32'h31000000);
      add_row(2, 81, 0, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(2, 82, 0, 0, 4'b1000, 4'b0000, 32'h32000000);
      add_row(2, 83, 1, 1, 4'b1000, 4'b0000, 32'h33000000);
      // scenario 3: reset during FLUSH, then a fresh frame at 100..103
      add_row(3, 36, 0, 0, 4'b0010, 4'b0000, 32'h00001300);
      add_row(3, 41, 0, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(3, 42, 1, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(3, 55, 1, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(3, 80, 1, 0, 4'b0000, 4'b0000, 32'h00000000);
      add_row(3, 101, 1, 0, 4'b0001, 4'b0001, 32'h00000004);
      add_row(3, 169, 0, 0, 4'b1000, 4'b0000, 32'h36000000);
      add_row(3, 170, 1, 1, 4'b1000, 4'b0000, 32'h37000000);
      // scenario 4: offer held through FLUSH
      add_row(4, 79, 0, 0, 4'b0000, 4'b0000, 32'h32000000 & 32'h0);
      add_row(4, 80, 1, 1, 4'b1000, 4'b0000, 32'h33000000);
      add_row(4, 81, 1, 0, 4'b0001, 4'b0001, 32'h00000004);
      rows[rows.size()-3].v = 4'b1000;
      rows[rows.size()-3].d = 32'h32000000;

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0;

      // reset held three cycles, outputs quiet, ready rises after release
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst.out_valid", 32'(out_valid), 32'h0);
         chk("rst.in_ready",  32'(in_ready),  32'h0);
      end
      rst = 1'b0;
      tick();
      chk("rst.release_ready", 32'(in_ready), 32'h1);
      for (int i = 0; i < 4; i++) tick();

      mask = '0;
      for (int j = 10; j <= 13; j++) mask[j] = 1'b1;
      run_scn(1, mask, 95, -1);

      mask = '0;
      mask[10] = 1'b1; mask[12] = 1'b1; mask[15] = 1'b1; mask[16] = 1'b1;
      run_scn(2, mask, 100, -1);

      mask = '0;
      for (int j = 10; j <= 13; j++) mask[j] = 1'b1;
      for (int j = 100; j <= 103; j++) mask[j] = 1'b1;
      run_scn(3, mask, 190, 40);

      mask = '0;
      for (int j = 10; j <= 80; j++) mask[j] = 1'b1;
      run_scn(4, mask, 100, -1);

      // randomized traffic with occasional resets, checked by the model
      for (int i = 0; i < 4000; i++) begin
         rst      = (i < 2) || ($urandom_range(0, 699) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = $urandom();
         tick();
      end
      rst = 1'b0; in_valid = 1'b0;

      // FRAME_LEN=1: one accept goes straight to FLUSH
      for (int j = 0; j < 80; j++) begin
         rst1      = (j < 3);
         in_valid1 = (j == 5);
         in_data1  = (j == 5) ? 32'h44332211 : 32'h0;
         @(posedge clk);
         #1;
         if (j == 2) chk("f1.rst_ready", 32'(in_ready1), 32'h0);
         if (j == 3) chk("f1.release_ready", 32'(in_ready1), 32'h1);
         if (j == 5) begin
            chk("f1.flush_ready", 32'(in_ready1),  32'h0);
            chk("f1.lane0_valid", 32'(out_valid1), 32'h1);
            chk("f1.lane0_sof",   32'(out_sof1),   32'h1);
            chk("f1.lane0_data",  out_data1,       32'h00000011);
         end
         if (j == 27) begin
            chk("f1.lane1_sof",  32'(out_sof1), 32'h2);
            chk("f1.lane1_data", out_data1,     32'h00002200);
         end
         if (j == 49) chk("f1.lane2_sof", 32'(out_sof1), 32'h4);
         if (j == 70) begin
            chk("f1.pre_done",  32'(frame_done1), 32'h0);
            chk("f1.pre_ready", 32'(in_ready1),   32'h0);
         end
         if (j == 71) begin
            chk("f1.done",       32'(frame_done1), 32'h1);
            chk("f1.done_ready", 32'(in_ready1),   32'h1);
            chk("f1.lane3_sof",  32'(out_sof1),    32'h8);
            chk("f1.lane3_data", out_data1,        32'h44000000);
         end
         if (j == 72) begin
            chk("f1.done_pulse", 32'(frame_done1), 32'h0);
            chk("f1.quiet",      32'(out_valid1),  32'h0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
